// File: rtl/normalize_pkg.sv
// Shared definitions for the dot-product back end: width helpers and the
// normaliser FSM state encoding.
package normalize_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LZC,
    ST_SHIFT,
    ST_ROUND,
    ST_OUT
  } state_t;

  function automatic int log2(input int value);
    return $clog2(value);
  endfunction

  function automatic int acc_width(input int x_width, input int m_width);
    return 2 * x_width + m_width + 2;
  endfunction

  function automatic int bias(input int e_width);
    return (1 << (e_width - 1)) - 1;
  endfunction

endpackage

// File: rtl/normalize_lzc.sv
// Leading-one position encoder: index of the most significant set bit, plus
// a flag for an all-zero input. Purely combinational.
module lzc #(
  parameter int WIDTH = 45,
  parameter int POS_W = normalize_pkg::log2(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  output logic [POS_W-1:0] pos,
  output logic             zero
);

  // Later (higher) hits overwrite earlier ones, so the MSB wins.
  always_comb begin
    pos = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) pos = POS_W'(i);
    end
  end

  assign zero = ~|value;

endmodule

// File: rtl/normalize.sv
// Converts the signed fixed-point adder-tree sum back into a packed float
// using a five-state FSM (magnitude, LZC, shift, round-to-nearest-even, out).
module normalize
  import normalize_pkg::*;
#(
  parameter int N          = 1024,
  parameter int DATA_WIDTH = 32,
  parameter int E_WIDTH    = 8,
  parameter int M_WIDTH    = 23,
  parameter int X_WIDTH    = log2(N),
  parameter int ACC_WIDTH  = acc_width(X_WIDTH, M_WIDTH)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [ACC_WIDTH-1:0]  acc_i,
  input  logic [E_WIDTH-1:0]    e_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int BP    = M_WIDTH + X_WIDTH;
  localparam int P_W   = log2(ACC_WIDTH);
  localparam int EXP_W = E_WIDTH + 2;
  localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'((1 << E_WIDTH) - 1);

  state_t state_reg, state_next;

  logic                  sign_reg;
  logic [ACC_WIDTH-1:0]  mag_reg;
  logic [E_WIDTH-1:0]    e_reg;
  logic                  zero_reg;
  logic [P_W-1:0]        p_reg;
  logic [EXP_W-1:0]      exp_reg;
  logic [M_WIDTH-1:0]    mant_reg;
  logic                  guard_reg;
  logic                  sticky_reg;
  logic [DATA_WIDTH-1:0] result_reg;
  logic                  valid_reg;

  logic [ACC_WIDTH-1:0]  mag_next;
  logic [P_W-1:0]        lzc_pos;
  logic                  lzc_zero;
  logic [EXP_W-1:0]      exp_next;
  logic [P_W-1:0]        shift_amt;
  logic [ACC_WIDTH-2:0]  shifted;
  logic                  round_up;
  logic [M_WIDTH:0]      mant_sum;
  logic [EXP_W-1:0]      exp_rnd;
  logic [DATA_WIDTH-1:0] result_next;

  lzc #(
    .WIDTH (ACC_WIDTH),
    .POS_W (P_W)
  ) u_lzc (
    .value (mag_reg),
    .pos   (lzc_pos),
    .zero  (lzc_zero)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (valid_i) state_next = ST_LZC;
      ST_LZC:   state_next = ST_SHIFT;
      ST_SHIFT: state_next = ST_ROUND;
      ST_ROUND: state_next = ST_OUT;
      ST_OUT:   if (ready_i) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign ready_o  = (state_reg == ST_IDLE);
  assign valid_o  = valid_reg;
  assign result_o = result_reg;

  // Unsigned negation covers the most negative input: it maps to 2^(ACC_WIDTH-1).
  assign mag_next = acc_i[ACC_WIDTH-1] ? (~acc_i + ACC_WIDTH'(1)) : acc_i;

  // Two guard bits of headroom keep e + p - BP from wrapping either way.
  assign exp_next = EXP_W'(e_reg) + EXP_W'(lzc_pos) - EXP_W'(BP);

  // The leading one itself is dropped by the truncation (hidden bit).
  assign shift_amt = P_W'(ACC_WIDTH - 1) - p_reg;
  assign shifted   = (ACC_WIDTH-1)'(mag_reg << shift_amt);

  assign round_up = guard_reg & (sticky_reg | mant_reg[0]);
  assign mant_sum = {1'b0, mant_reg} + (M_WIDTH+1)'(round_up);
  assign exp_rnd  = exp_reg + EXP_W'(mant_sum[M_WIDTH]);

  always_comb begin
    result_next = '0;
    if (zero_reg) begin
      result_next = '0;
    end else if (!exp_rnd[EXP_W-1] && (exp_rnd >= EXP_MAX)) begin
      result_next = {sign_reg, {E_WIDTH{1'b1}}, {M_WIDTH{1'b0}}};
    end else if (exp_rnd[EXP_W-1] || (exp_rnd == '0)) begin
      result_next = {sign_reg, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      result_next = {sign_reg, exp_rnd[E_WIDTH-1:0], mant_sum[M_WIDTH-1:0]};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sign_reg   <= 1'b0;
      mag_reg    <= '0;
      e_reg      <= '0;
      zero_reg   <= 1'b0;
      p_reg      <= '0;
      exp_reg    <= '0;
      mant_reg   <= '0;
      guard_reg  <= 1'b0;
      sticky_reg <= 1'b0;
      result_reg <= '0;
      valid_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (valid_i) begin
            sign_reg <= acc_i[ACC_WIDTH-1];
            mag_reg  <= mag_next;
            e_reg    <= e_i;
          end
        end
        ST_LZC: begin
          zero_reg <= lzc_zero;
          p_reg    <= lzc_pos;
          exp_reg  <= exp_next;
        end
        ST_SHIFT: begin
          mant_reg   <= shifted[ACC_WIDTH-2 -: M_WIDTH];
          guard_reg  <= shifted[ACC_WIDTH-2-M_WIDTH];
          sticky_reg <= |shifted[ACC_WIDTH-3-M_WIDTH:0];
        end
        ST_ROUND: begin
          result_reg <= result_next;
          valid_reg  <= 1'b1;
        end
        ST_OUT: begin
          if (ready_i) valid_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_normalize.sv
// Randomised and directed bench for normalize, checked against an arithmetic
// float-conversion model (integer divide/remainder rounding).
module tb_normalize;

  localparam int ACC_W = 45;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             valid_i = 1'b0;
  logic             ready_i = 1'b1;
  logic [ACC_W-1:0] acc_i = '0;
  logic [7:0]       e_i = '0;
  logic             ready_o;
  logic             valid_o;
  logic [31:0]      result_o;

  int total = 0;
  int bad   = 0;

  normalize dut (
    .clock    (clock),
    .resetn   (resetn),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .acc_i    (acc_i),
    .e_i      (e_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o)
  );

  always #5 clock = ~clock;

  // value = acc * 2^(e - 127 - 33); rounded to 24 significant bits.
  function automatic logic [31:0] model(input logic [ACC_W-1:0] acc, input logic [7:0] e);
    longint a, mag, q, rem, half;
    int p, s, ex;
    logic sgn;
    a   = longint'($signed(acc));
    sgn = (a < 0);
    mag = sgn ? -a : a;
    if (mag == 0) return 32'h0;
    p = 0;
    for (int i = 0; i < 46; i++) if (mag >= (longint'(1) << i)) p = i;
    s  = p - 23;
    ex = int'(e) + p - 33;
    if (s > 0) begin
      q    = mag >> s;
      rem  = mag - (q << s);
      half = longint'(1) << (s - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
    end else begin
      q = mag << (-s);
    end
    if (q == (longint'(1) << 24)) begin
      q  = q >> 1;
      ex = ex + 1;
    end
    if (ex >= 255) return {sgn, 8'hFF, 23'h0};
    if (ex <= 0)   return {sgn, 31'h0};
    return {sgn, ex[7:0], q[22:0]};
  endfunction

  // Called at posedge+1; returns result and edges from accept to valid_o.
  task automatic op(input logic [ACC_W-1:0] a, input logic [7:0] e,
                    output logic [31:0] res, output int lat);
    int waited;
    waited = 0;
    while (ready_o !== 1'b1 && waited < 50) begin
      @(posedge clock); #1;
      waited++;
    end
    acc_i   = a;
    e_i     = e;
    valid_i = 1'b1;
    @(posedge clock); #1;
    valid_i = 1'b0;
    acc_i   = {$urandom, $urandom};
    lat = 0;
    while (valid_o !== 1'b1 && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
    res = result_o;
    if (ready_i) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #1;
    total++;
    if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    total++;
    if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    total++;
    if (result_o !== 32'h0) begin bad++; $display("FAIL reset_result: got %h want 00000000", result_o); end
    repeat (3) @(posedge clock);
    #1;
    resetn = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_directed();
    logic [ACC_W-1:0] acc_tab [10];
    logic [7:0]       e_tab   [10];
    logic [31:0]      exp_tab [10];
    logic [31:0]      res;
    int               lat;
    longint           t;
    acc_tab[0] = 45'd1 << 33;                         e_tab[0] = 8'd127; exp_tab[0] = 32'h3F800000;
    t = -(longint'(3) << 32);
    acc_tab[1] = t[ACC_W-1:0];                        e_tab[1] = 8'd127; exp_tab[1] = 32'hBFC00000;
    acc_tab[2] = 45'd1 << 44;                         e_tab[2] = 8'd100; exp_tab[2] = 32'hB7800000;
    acc_tab[3] = (45'd1 << 33) | (45'd1 << 9);        e_tab[3] = 8'd127; exp_tab[3] = 32'h3F800000;
    acc_tab[4] = (45'd1 << 33) | (45'd3 << 9);        e_tab[4] = 8'd127; exp_tab[4] = 32'h3F800002;
    acc_tab[5] = 45'h3_FFFF_FFFF;                     e_tab[5] = 8'd127; exp_tab[5] = 32'h40000000;
    acc_tab[6] = '0;                                  e_tab[6] = 8'd200; exp_tab[6] = 32'h00000000;
    acc_tab[7] = 45'd1 << 43;                         e_tab[7] = 8'd250; exp_tab[7] = 32'h7F800000;
    acc_tab[8] = 45'd1;                               e_tab[8] = 8'd20;  exp_tab[8] = 32'h00000000;
    acc_tab[9] = '1;                                  e_tab[9] = 8'd20;  exp_tab[9] = 32'h80000000;
    for (int i = 0; i < 10; i++) begin
      op(acc_tab[i], e_tab[i], res, lat);
      $display("directed %0d acc=%h e=%0d result=%h latency=%0d", i, acc_tab[i], e_tab[i], res, lat);
      total++;
      if (res !== exp_tab[i]) begin bad++; $display("FAIL directed_%0d: got %h want %h", i, res, exp_tab[i]); end
      total++;
      if (lat != 3) begin bad++; $display("FAIL latency_%0d: got %0d want 3", i, lat); end
      total++;
      if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
        bad++; $display("FAIL handoff_%0d: got valid=%b ready=%b want valid=0 ready=1", i, valid_o, ready_o);
      end
    end
  endtask

  task automatic test_random();
    logic signed [ACC_W-1:0] s;
    logic [ACC_W-1:0]        mask;
    logic [7:0]              e;
    logic [31:0]             res, want;
    int                      lat;
    for (int i = 0; i < 300; i++) begin
      s = ACC_W'({$urandom, $urandom});
      s = s >>> $urandom_range(0, 44);
      if ($urandom_range(0, 3) == 0) begin
        mask = '1;
        mask = mask << $urandom_range(1, 30);
        s = s & mask;
      end
      e    = 8'($urandom_range(0, 255));
      want = model(s, e);
      op(s, e, res, lat);
      $display("random %0d acc=%h e=%0d result=%h", i, s, e, res);
      total++;
      if (res !== want || lat != 3) begin
        bad++; $display("FAIL random_%0d: got %h lat %0d want %h lat 3", i, res, lat, want);
      end
    end
  endtask

  task automatic test_handshake();
    logic [ACC_W-1:0] a;
    logic [31:0]      want, held;
    a    = (45'd5 << 31) | 45'd12345;
    want = model(a, 8'd130);
    ready_i = 1'b0;
    acc_i   = a;
    e_i     = 8'd130;
    valid_i = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ready_o !== 1'b0) begin bad++; $display("FAIL busy_ready_%0d: got %b want 0", i, ready_o); end
      valid_i = 1'($urandom_range(0, 1));
      acc_i   = {$urandom, $urandom};
      @(posedge clock); #1;
    end
    total++;
    if (valid_o !== 1'b1 || result_o !== want) begin
      bad++; $display("FAIL hs_result: got valid=%b %h want valid=1 %h", valid_o, result_o, want);
    end
    held = result_o;
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'($urandom_range(0, 1));
      acc_i   = {$urandom, $urandom};
      @(posedge clock); #1;
      $display("stall %0d valid_o=%b result=%h ready_o=%b", i, valid_o, result_o, ready_o);
      total++;
      if (valid_o !== 1'b1 || result_o !== held || ready_o !== 1'b0) begin
        bad++; $display("FAIL stall_%0d: got valid=%b %h ready=%b want valid=1 %h ready=0",
                        i, valid_o, result_o, ready_o, held);
      end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clock); #1;
    total++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      bad++; $display("FAIL hs_release: got valid=%b ready=%b want valid=0 ready=1", valid_o, ready_o);
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      total++;
      if (valid_o !== 1'b0) begin bad++; $display("FAIL ghost_%0d: got valid=%b want 0", i, valid_o); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int          lat;
    acc_i   = 45'd3 << 40;
    e_i     = 8'd90;
    valid_i = 1'b1;
    @(posedge clock); #1;
    valid_i = 1'b0;
    @(posedge clock); #1;
    resetn = 1'b0;
    #1;
    $display("reset mid-op valid_o=%b ready_o=%b result=%h", valid_o, ready_o, result_o);
    total++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || result_o !== 32'h0) begin
      bad++; $display("FAIL midreset: got valid=%b ready=%b %h want valid=0 ready=1 00000000",
                      valid_o, ready_o, result_o);
    end
    repeat (2) @(posedge clock);
    #3;
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      total++;
      if (valid_o !== 1'b0) begin bad++; $display("FAIL post_reset_%0d: got valid=%b want 0", i, valid_o); end
    end
    op(45'd1 << 33, 8'd127, res, lat);
    $display("after reset result=%h latency=%0d", res, lat);
    total++;
    if (res !== 32'h3F800000 || lat != 3) begin
      bad++; $display("FAIL after_reset: got %h lat %0d want 3f800000 lat 3", res, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [ACC_W-1:0] a, b;
    int               acc_edges[$];
    logic [31:0]      res_q[$];
    int               lat;
    a = 45'h0_1234_5678_9AB;
    b = ~(45'd7 << 20);
    ready_i = 1'b1;
    acc_i   = a;
    e_i     = 8'd140;
    valid_i = 1'b1;
    for (int c = 0; c < 40 && acc_edges.size() < 2; c++) begin
      if (ready_o === 1'b1) acc_edges.push_back(c);
      if (valid_o === 1'b1) res_q.push_back(result_o);
      @(posedge clock); #1;
      if (acc_edges.size() == 1) begin
        acc_i = b;
        e_i   = 8'd60;
      end
    end
    valid_i = 1'b0;
    lat = 0;
    while (valid_o !== 1'b1 && lat < 50) begin
      @(posedge clock); #1;
      lat++;
    end
    if (valid_o === 1'b1) res_q.push_back(result_o);
    @(posedge clock); #1;
    total++;
    if (acc_edges.size() != 2 || acc_edges[1] - acc_edges[0] != 5) begin
      bad++; $display("FAIL b2b_interval: got %0d accepts spacing %0d want 2 accepts spacing 5",
                      acc_edges.size(), (acc_edges.size() == 2) ? acc_edges[1] - acc_edges[0] : -1);
    end
    total++;
    if (res_q.size() != 2) begin
      bad++; $display("FAIL b2b_count: got %0d results want 2", res_q.size());
    end else begin
      $display("b2b results %h %h", res_q[0], res_q[1]);
      if (res_q[0] !== model(a, 8'd140) || res_q[1] !== model(b, 8'd60)) begin
        bad++; $display("FAIL b2b_results: got %h %h want %h %h",
                        res_q[0], res_q[1], model(a, 8'd140), model(b, 8'd60));
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_handshake();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
